// File: rtl/imem_loader.sv
// imem_loader
// Boot-time loader that fills instruction memory from a length-prefixed,
// XOR-checksummed byte stream before the core is released.
//
// Stream: N lo, N hi (word count), 4*N data bytes (little-endian words),
// then one checksum byte equal to the XOR of all data bytes.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a load (honoured only in IDLE, DONE or ERR)
//   rx_data/rx_valid  incoming stream byte and its valid flag
//   rx_ready          loader accepts a byte this cycle (registered)
//   wr_en/wr_addr/wr_data  one-cycle instruction-memory write per word
//   cpu_hold          keeps the core stalled until a verified image is in place
//   done/error        load verified / load failed (oversize or bad checksum)
//   words_loaded      words written in the current or last load
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t      state_r;
  logic        hdr_cnt_r;   // 0: expecting N lo, 1: expecting N hi
  logic [7:0]  n_lo_r;
  logic [15:0] n_r;
  logic [15:0] word_cnt_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] word_buf_r;  // bytes 0..2 of the word being assembled
  logic [7:0]  csum_r;

  logic        take_s;
  logic [15:0] n_hdr_s;
  logic        oversize_s;

  // Running checksum update: plain XOR of every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // A byte moves only when both sides agree; rx_ready is a register, so no
  // output ever depends combinationally on rx_valid/rx_data.
  assign take_s     = rx_valid & rx_ready;
  assign n_hdr_s    = {rx_data, n_lo_r};
  assign oversize_s = ({16'd0, n_hdr_s} > MAX_WORDS);

  // Loader state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      hdr_cnt_r    <= 1'b0;
      n_lo_r       <= 8'd0;
      n_r          <= 16'd0;
      word_cnt_r   <= 16'd0;
      byte_cnt_r   <= 2'd0;
      word_buf_r   <= 24'd0;
      csum_r       <= 8'd0;
      rx_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_r      <= HDR;
            hdr_cnt_r    <= 1'b0;
            word_cnt_r   <= 16'd0;
            byte_cnt_r   <= 2'd0;
            csum_r       <= 8'd0;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
          end
        end
        HDR: begin
          if (take_s) begin
            if (!hdr_cnt_r) begin
              n_lo_r    <= rx_data;
              hdr_cnt_r <= 1'b1;
            end else begin
              n_r <= n_hdr_s;
              if (oversize_s) begin
                state_r  <= ERR;
                rx_ready <= 1'b0;
                error    <= 1'b1;
              end else if (n_hdr_s == 16'd0) begin
                state_r <= CSUM;
              end else begin
                state_r <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (take_s) begin
            csum_r     <= csum_next(csum_r, rx_data);
            byte_cnt_r <= byte_cnt_r + 2'd1;  // wraps to 0 after byte 3
            case (byte_cnt_r)
              2'd0: word_buf_r[7:0]   <= rx_data;
              2'd1: word_buf_r[15:8]  <= rx_data;
              2'd2: word_buf_r[23:16] <= rx_data;
              2'd3: begin
                wr_en        <= 1'b1;
                wr_addr      <= ADDR_WIDTH'({word_cnt_r, 2'b00});
                wr_data      <= {rx_data, word_buf_r};
                word_cnt_r   <= word_cnt_r + 16'd1;
                words_loaded <= word_cnt_r + 16'd1;
                // The last write lands in the first CSUM cycle; rx_ready stays up.
                if (word_cnt_r == n_r - 16'd1) begin
                  state_r <= CSUM;
                end
              end
              default: word_buf_r <= word_buf_r;
            endcase
          end
        end
        CSUM: begin
          if (take_s) begin
            rx_ready <= 1'b0;
            if (rx_data == csum_r) begin
              state_r  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= ERR;
              error   <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cases from the test plan plus
// randomized loads, checked against a byte-stream reference model.
module tb_imem_loader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] img [8];
  logic [63:0] got_q [$];

  imem_loader #(.ADDR_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  rx_ready, 1'b0);
    check({tag, "_wen"},  wr_en, 1'b0);
    check({tag, "_addr"}, wr_addr, 32'd0);
    check({tag, "_data"}, wr_data, 32'd0);
    check({tag, "_hold"}, cpu_hold, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"},  error, 1'b0);
    check({tag, "_wl"},   words_loaded, 16'd0);
  endtask

  // Offer one byte until it is accepted; handshake decided from the values
  // present just before the rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit st);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 64) begin
      @(negedge clk);
      rx_data  = b;
      start    = st;
      rx_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      hs       = rx_valid && rx_ready;
      @(posedge clk);
      guard++;
    end
    if (!hs) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_rdy",  rx_ready, 1'b1);
    check("start_done", done, 1'b0);
    check("start_err",  error, 1'b0);
    check("start_hold", cpu_hold, 1'b1);
    check("start_wl",   words_loaded, 16'd0);
  endtask

  // Full load of img[0..n-1]; csum_flip corrupts the checksum when nonzero.
  task automatic run_load(input int n, input logic [7:0] csum_flip, input bit gaps, input bit poke);
    logic [7:0] cs;
    logic [31:0] w;
    bit exp_ok;
    got_q.delete();
    pulse_start();
    send_byte(n[7:0], gaps, 1'b0);
    send_byte(n[15:8], gaps, 1'b0);
    if (n > MAXW) begin
      @(negedge clk);
      rx_valid = 1'b0;
      check("ovs_err",  error, 1'b1);
      check("ovs_rdy",  rx_ready, 1'b0);
      check("ovs_done", done, 1'b0);
      check("ovs_hold", cpu_hold, 1'b1);
      repeat (4) @(negedge clk);
      check("ovs_nwr", got_q.size(), 0);
      check("ovs_wl",  words_loaded, 16'd0);
      return;
    end
    cs = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = img[k];
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ w[8*j +: 8];
        send_byte(w[8*j +: 8], gaps, poke && (k == 0) && (j == 1));
      end
    end
    exp_ok = (csum_flip == 8'd0);
    send_byte(cs ^ csum_flip, gaps, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("end_done", done, exp_ok);
    check("end_err",  error, !exp_ok);
    check("end_hold", cpu_hold, !exp_ok);
    check("end_rdy",  rx_ready, 1'b0);
    check("end_wl",   words_loaded, n[15:0]);
    repeat (4) @(negedge clk);
    check("wr_count", got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++)
      check($sformatf("wr%0d", k), got_q[k], {32'(4 * k), img[k]});
  endtask

  initial begin
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Single word from the test plan: checksum B4 over 13 05 A0 02.
    img[0] = 32'h02A00513;
    run_load(1, 8'h00, 1'b0, 1'b0);
    check("single_data", got_q.size() > 0 ? got_q[0] : 64'd0, 64'h0000_0000_02A0_0513);

    // Three words with rx_valid gaps, start poked mid-load (ignored).
    img[0] = 32'h11223344; img[1] = 32'hA5A55A5A; img[2] = 32'hDEADBEEF;
    run_load(3, 8'h00, 1'b1, 1'b1);

    // Zero-length image: good then bad checksum.
    run_load(0, 8'h00, 1'b0, 1'b0);
    run_load(0, 8'h01, 1'b0, 1'b0);

    // Oversize header 05 00, then a normal load clears error.
    run_load(5, 8'h00, 1'b0, 1'b0);
    img[0] = 32'hCAFEF00D; img[1] = 32'h01020304;
    run_load(2, 8'h80, 1'b0, 1'b0);

    // Reset after 5 data bytes of a 3-word load.
    got_q.delete();
    pulse_start();
    send_byte(8'd3, 1'b0, 1'b0);
    send_byte(8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h40), 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_wr", got_q.size(), 1);
    @(negedge clk);
    rst = 1'b0;
    img[0] = 32'h00000013; img[1] = 32'hFFFFFFFF; img[2] = 32'h80000001;
    run_load(3, 8'h00, 1'b0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int k = 0; k < 8; k++) img[k] = $urandom;
      run_load(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
